// File: rtl/uart_tx_feeder_if.sv
// ============================================================================
// Module   : uart_tx_feeder_if
// Brief    : Bus-side write port and transmitter handshake of uart_tx_feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_feeder_if #(
  parameter int CW = 5
);
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;
  logic [7:0]    data_tx;
  logic          transmit;
  logic          busy;

  // master: the bus writer together with the UART transmitter
  modport master (
    output wr_data, wr_en, ovf_clr, busy,
    input  full, empty, count, overflow, data_tx, transmit
  );

  // slave: the feeder itself
  modport slave (
    input  wr_data, wr_en, ovf_clr, busy,
    output full, empty, count, overflow, data_tx, transmit
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ============================================================================
// Module   : uart_tx_feeder
// Brief    : Byte FIFO plus request sequencer feeding a UART transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_feeder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic [7:0]    r_data_tx;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The FSM only looks at registered empty, so a fresh write is seen one cycle later
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && !bus.busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.busy) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a write at full is still accepted
  assign w_push = bus.wr_en && (!r_full || w_pop);
  assign w_drop = bus.wr_en && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_data_tx  <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_data_tx <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; at full the head is read before the same slot is overwritten
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.data_tx  = r_data_tx;
  assign bus.transmit = (r_state == S_REQ);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
// ============================================================================
// Module   : tb_uart_tx_feeder
// Brief    : Scoreboard bench for uart_tx_feeder with a simple UART TX model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  localparam int M_IDLE  = 0;
  localparam int M_DELAY = 1;
  localparam int M_BUSY  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_feeder_if #(.CW(CW)) bus_if ();

  uart_tx_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         sent_cnt = 0;
  logic [7:0] last_sent = 8'h00;

  bit         model_en  = 1'b0;
  logic       hold_busy = 1'b0;
  int         raise_dly = 0;
  int         frame_len = 4;
  int         mstate    = M_IDLE;
  int         dcnt      = 0;
  int         bcnt      = 0;
  int         idle_cnt  = 0;
  bit         b2b       = 1'b0;
  logic [7:0] held      = 8'h00;

  // Transmitter accepts the request: busy rises and the byte is scored
  task automatic do_raise();
    logic [7:0] exp;
    bus_if.busy = 1'b1;
    bcnt        = 0;
    mstate      = M_BUSY;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_request: got data_tx=%02h, required no request", bus_if.data_tx);
    end else begin
      exp = exp_q.pop_front();
      if (bus_if.data_tx !== exp) begin
        errors++;
        $display("FAIL tx_byte: got %02h, required %02h", bus_if.data_tx, exp);
      end
    end
    sent_cnt++;
    last_sent = bus_if.data_tx;
  endtask

  // UART TX model, evaluated on the inactive edge; sole driver of busy
  always @(negedge clk) begin
    if (rst || !model_en) begin
      mstate   = M_IDLE;
      idle_cnt = 0;
      b2b      = 1'b0;
      bus_if.busy = model_en ? 1'b0 : hold_busy;
    end else begin
      case (mstate)
        M_IDLE: begin
          bus_if.busy = 1'b0;
          idle_cnt++;
          if (b2b && idle_cnt == 1) begin
            checks++;
            if (bus_if.transmit !== 1'b0) begin
              errors++;
              $display("FAIL b2b_early: transmit=%b, required 0", bus_if.transmit);
            end
          end
          if (b2b && idle_cnt == 2) begin
            checks++;
            if (bus_if.transmit !== 1'b1) begin
              errors++;
              $display("FAIL b2b_latency: transmit=%b, required 1", bus_if.transmit);
            end
            b2b = 1'b0;
          end
          if (bus_if.transmit === 1'b1) begin
            held = bus_if.data_tx;
            if (raise_dly == 0) begin
              do_raise();
            end else begin
              dcnt   = raise_dly;
              mstate = M_DELAY;
            end
          end
        end
        M_DELAY: begin
          checks++;
          if (bus_if.transmit !== 1'b1 || bus_if.data_tx !== held) begin
            errors++;
            $display("FAIL req_hold: transmit=%b data_tx=%02h, required 1 and %02h",
                     bus_if.transmit, bus_if.data_tx, held);
          end
          dcnt--;
          if (dcnt == 0) do_raise();
        end
        default: begin
          checks++;
          if (bus_if.transmit !== 1'b0) begin
            errors++;
            $display("FAIL req_drop: transmit=%b while busy, required 0", bus_if.transmit);
          end
          bcnt++;
          if (bcnt >= frame_len) begin
            bus_if.busy = 1'b0;
            mstate      = M_IDLE;
            idle_cnt    = 0;
            b2b         = (exp_q.size() > 0);
          end
        end
      endcase
    end
  end

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mstate == M_IDLE && bus_if.busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d bytes still expected, required 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = 8'h5A;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.wr_en = 1'b0;
    checks++; if (bus_if.count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", bus_if.count); end
    checks++; if (bus_if.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b, required 1", bus_if.empty); end
    checks++; if (bus_if.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b, required 0", bus_if.full); end
    checks++; if (bus_if.transmit !== 1'b0) begin errors++; $display("FAIL rst_transmit: got %b, required 0", bus_if.transmit); end
    checks++; if (bus_if.data_tx !== 8'h00) begin errors++; $display("FAIL rst_data_tx: got %02h, required 00", bus_if.data_tx); end
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", bus_if.overflow); end
  endtask

  task automatic test_single_byte();
    int base = sent_cnt;
    raise_dly = 5; frame_len = 10; model_en = 1'b1;
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    bus_if.wr_en = 1'b0;
    checks++;
    if (bus_if.empty !== 1'b0 || bus_if.count !== 5'd1 || bus_if.transmit !== 1'b0) begin
      errors++;
      $display("FAIL single_edgeN: empty=%b count=%0d transmit=%b, required 0 1 0",
               bus_if.empty, bus_if.count, bus_if.transmit);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.transmit !== 1'b1 || bus_if.data_tx !== 8'hA5) begin
      errors++;
      $display("FAIL single_req: transmit=%b data_tx=%02h, required 1 a5", bus_if.transmit, bus_if.data_tx);
    end
    wait_drain("single");
    checks++; if (bus_if.count !== 5'd0) begin errors++; $display("FAIL single_count: got %0d, required 0", bus_if.count); end
    checks++; if (sent_cnt - base !== 1) begin errors++; $display("FAIL single_sent: got %0d, required 1", sent_cnt - base); end
  endtask

  task automatic test_ordering();
    int base = sent_cnt;
    logic [7:0] b;
    raise_dly = 2; frame_len = 100;
    for (int i = 1; i <= 3; i++) begin
      b = 8'(i);
      bus_if.wr_en = 1'b1; bus_if.wr_data = b; exp_q.push_back(b);
      @(posedge clk); #1;
    end
    bus_if.wr_en = 1'b0;
    wait_drain("order");
    checks++; if (sent_cnt - base !== 3) begin errors++; $display("FAIL order_sent: got %0d, required 3", sent_cnt - base); end
    checks++; if (last_sent !== 8'h03) begin errors++; $display("FAIL order_last: got %02h, required 03", last_sent); end
  endtask

  task automatic test_full_overflow();
    int base;
    model_en = 1'b0; hold_busy = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h80 + 8'(i);
      if (i < 16) exp_q.push_back(8'h80 + 8'(i));
      @(posedge clk); #1;
      if (i == 15) begin
        checks++;
        if (bus_if.full !== 1'b1 || bus_if.overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill_16: full=%b overflow=%b, required 1 0", bus_if.full, bus_if.overflow);
        end
      end
    end
    bus_if.wr_en = 1'b0;
    checks++; if (bus_if.count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d, required 16", bus_if.count); end
    checks++; if (bus_if.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b, required 1", bus_if.full); end
    checks++; if (bus_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", bus_if.overflow); end
    bus_if.ovf_clr = 1'b1; @(posedge clk); #1; bus_if.ovf_clr = 1'b0;
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b, required 0", bus_if.overflow); end
    // drop and clear together: the set wins
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hEE; bus_if.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus_if.wr_en = 1'b0; bus_if.ovf_clr = 1'b0;
    checks++; if (bus_if.overflow !== 1'b1 || bus_if.count !== 5'd16) begin
      errors++; $display("FAIL ovf_set_wins: overflow=%b count=%0d, required 1 16", bus_if.overflow, bus_if.count);
    end
    bus_if.ovf_clr = 1'b1; @(posedge clk); #1; bus_if.ovf_clr = 1'b0;
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2: got %b, required 0", bus_if.overflow); end

    // release busy and write in the pop cycle
    base = sent_cnt;
    raise_dly = 1; frame_len = 4; model_en = 1'b1;
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'h55; exp_q.push_back(8'h55);
    @(posedge clk); #1;
    bus_if.wr_en = 1'b0;
    checks++;
    if (bus_if.count !== 5'd16 || bus_if.overflow !== 1'b0 || bus_if.full !== 1'b1 ||
        bus_if.transmit !== 1'b1 || bus_if.data_tx !== 8'h80) begin
      errors++;
      $display("FAIL simul_pop: count=%0d ovf=%b full=%b tx=%b data=%02h, required 16 0 1 1 80",
               bus_if.count, bus_if.overflow, bus_if.full, bus_if.transmit, bus_if.data_tx);
    end
    wait_drain("full");
    checks++; if (sent_cnt - base !== 17) begin errors++; $display("FAIL full_sent: got %0d, required 17", sent_cnt - base); end
    checks++; if (last_sent !== 8'h55) begin errors++; $display("FAIL full_last: got %02h, required 55", last_sent); end
  endtask

  task automatic test_reset_in_req();
    int base = sent_cnt;
    bit saw_tx = 1'b0;
    raise_dly = 10; frame_len = 5;
    for (int i = 0; i < 5; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hC0 + 8'(i);
      @(posedge clk); #1;
    end
    bus_if.wr_en = 1'b0;
    checks++;
    if (bus_if.transmit !== 1'b1 || bus_if.count !== 5'd4) begin
      errors++;
      $display("FAIL pre_rst: transmit=%b count=%0d, required 1 4", bus_if.transmit, bus_if.count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus_if.transmit !== 1'b0 || bus_if.count !== 5'd0 || bus_if.empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_req: transmit=%b count=%0d empty=%b, required 0 0 1",
               bus_if.transmit, bus_if.count, bus_if.empty);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus_if.transmit !== 1'b0) saw_tx = 1'b1;
    end
    checks++;
    if (saw_tx || sent_cnt != base) begin
      errors++;
      $display("FAIL rst_no_send: saw_transmit=%b sent=%0d, required 0 0", saw_tx, sent_cnt - base);
    end
  endtask

  initial begin
    bus_if.wr_en   = 1'b0;
    bus_if.wr_data = 8'h00;
    bus_if.ovf_clr = 1'b0;
    test_reset();
    test_single_byte();
    test_ordering();
    test_full_overflow();
    test_reset_in_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and request sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the processor/bus side in single-cycle writes, buffers up to DEPTH of them, and presents them one at a time on `data_tx`/`transmit`. It follows the transmitter's `busy` handshake so that no byte is lost or sent twice, regardless of where the transmitter is in its baud-tick cycle.

## Interface
- `DEPTH`, default 16: FIFO depth in bytes; a power of two, ≥2.
- `CW`, default `$clog2(DEPTH)+1`: width of the `count` output.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_data`  in  8: byte to enqueue.
- `wr_en`  in  1: enqueue strobe, one byte per cycle when high.
- `full`  out  1: FIFO holds DEPTH bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  CW: number of bytes stored; 0..DEPTH.
- `overflow`  out  1: sticky flag; a write was dropped.
- `ovf_clr`  in  1: clears `overflow`.
- `data_tx`  out  8: byte presented to the transmitter.
- `transmit`  out  1: transmit request level to the transmitter.
- `busy`  in  1: transmitter busy, from the UART TX.

## Operation
- FIFO is a circular buffer with read and write pointers of log2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. `count` is tracked explicitly.
- Write: if `wr_en` is high and (`!full` or a pop occurs in the same cycle), `wr_data` is stored at the write pointer and the pointer increments.
- Write with `wr_en` high, `full` high and no pop in the same cycle: the byte is dropped and `overflow` is set to 1.
- `overflow` holds until `ovf_clr` is asserted. If a drop and `ovf_clr` occur in the same cycle, the set wins and `overflow` stays 1.
- Simultaneous write and pop: `count` is unchanged and both pointers advance.
- A pop happens only on the IDLE→REQ transition.

FSM, 3 states:
- IDLE: `transmit` = 0. If `!empty` and `!busy`, then in the same cycle: `data_tx` ← FIFO head, pop, `transmit` ← 1, go to REQ.
- REQ: hold `transmit` = 1 and keep `data_tx` stable. When `busy` is sampled 1: `transmit` ← 0, go to WAIT_DONE. There is no timeout; the block waits indefinitely for `busy`.
- WAIT_DONE: `transmit` = 0. When `busy` is sampled 0, go to IDLE.

Further rules:
- `data_tx` changes only on the IDLE→REQ transition. Between transitions it retains the last byte sent.
- A FIFO write to an empty FIFO is not visible to the FSM until the following cycle (the FSM sees registered `empty`).

## Timing
- Reset values: `transmit` = 0, `data_tx` = 8'h00, `empty` = 1, `full` = 0, `count` = 0, `overflow` = 0. FSM = IDLE, both pointers = 0. FIFO contents are not reset.
- `full`, `empty`, `count` and `overflow` are registered and reflect operations from the previous edge.
- Write-to-transmit latency with an empty FIFO and `busy` = 0:
  - `wr_en` is sampled at edge N.
  - `empty` = 0 after edge N.
  - `transmit` = 1 and `data_tx` are valid after edge N+1.
- `transmit` stays high for at least 1 cycle and until `busy` is seen high. This covers transmitters that only act on an internal baud tick.
- Back-to-back bytes: the next IDLE→REQ transition occurs 1 cycle after `busy` is sampled low in WAIT_DONE.
- Reset mid-operation, in any state: the FSM returns to IDLE, `transmit` = 0 on the next cycle, and all queued bytes are discarded. A frame already started in the transmitter is not this block's concern.

## Test plan
- Reset: assert `rst` for 2 cycles with `wr_en` = 1 → after release, `count` = 0, `empty` = 1, `transmit` = 0, `data_tx` = 8'h00, `overflow` = 0.
- Single byte: write 8'hA5 with `busy` = 0 → `transmit` = 1 and `data_tx` = 8'hA5 two cycles later. The bench model raises `busy` 5 cycles later and `transmit` is still 1 until then; `transmit` falls 1 cycle after `busy` = 1; `count` returns to 0.
- Ordering: write 8'h01, 8'h02, 8'h03 back-to-back against a UART TX model with 100-cycle frames → exactly three requests, in order 01, 02, 03. Each new request comes only after `busy` falls; no duplicates.
- Full and overflow: hold `busy` = 1 and write 17 bytes → `count` = 16, `full` = 1, `overflow` = 1, and the 17th byte is never transmitted. Pulse `ovf_clr` → `overflow` = 0.
- Simultaneous write and pop at full: while full in IDLE, drop `busy` and write 8'h55 in the pop cycle → the write is accepted, `count` stays 16, `overflow` stays 0, and 8'h55 is the last byte sent.
- Reset in REQ: assert `rst` while `transmit` = 1 with 4 bytes queued → next cycle `transmit` = 0, `count` = 0, and nothing further is sent.
